// File: rtl/lms_ctr_ram_loader_if.sv
// lms_ctr_ram_loader_if: Avalon-MM RAM port plus byte-stream handshake for the lms_ctr RAM loader
//  address/chipselect/write/byteenable/writedata/clken : loader -> RAM (s2 port)
//  readdata                                            : RAM -> loader, valid 1 cycle after a read address
//  s_data/s_valid                                      : byte source -> loader
//  s_ready                                             : loader -> byte source
//  modports: master (loader side), slave (RAM and byte source side)
interface lms_ctr_ram_loader_if #(parameter int ADDR_W = 14);
  logic [ADDR_W-1:0] address;
  logic chipselect;
  logic write;
  logic [3:0] byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic clken;
  logic [7:0] s_data;
  logic s_valid;
  logic s_ready;
  modport master(output address, chipselect, write, byteenable, writedata, clken, s_ready,
                 input readdata, s_data, s_valid);
  modport slave(input address, chipselect, write, byteenable, writedata, clken, s_ready,
                output readdata, s_data, s_valid);
endinterface

// File: rtl/lms_ctr_ram_loader.sv
// lms_ctr_ram_loader: packs a little-endian byte stream into 32-bit words and writes them to the lms_ctr RAM
//  clk, reset_n      : clock, asynchronous active-low reset
//  start, abort      : start pulse (latches base_addr/byte_len in IDLE), abort back to IDLE
//  base_addr,byte_len: first word address, number of bytes
//  bus (master)      : Avalon-MM RAM port and byte-stream handshake
//  busy, done, error : run in progress, end-of-run pulse, sticky range/checksum failure
//  Optional feature macro LOADER_VERIFY_EN: checksum readback pass after the last write.
module lms_ctr_ram_loader #(
  parameter int ADDR_W = 14,
  parameter int DEPTH_WORDS = 12288,
  parameter int LEN_W = 16
)(
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0] byte_len,
  lms_ctr_ram_loader_if.master bus,
  output logic busy,
  output logic done,
  output logic error
);
  typedef enum logic [2:0] {IDLE, FILL, WRITE, VRD, VCHK, FINISH} state_t;
  state_t state;
  logic [LEN_W-1:0] rem;
  logic [1:0] lane;
  logic [LEN_W:0] nwords;
  logic range_bad;
  assign nwords = ({1'b0, byte_len} + (LEN_W+1)'(3)) >> 2;
  assign range_bad = 32'(base_addr) + 32'(nwords) > 32'(DEPTH_WORDS);
  // byteenable for a word holding k+1 bytes
  function automatic logic [3:0] lane_be(input logic [1:0] k);
    return k == 2'd3 ? 4'hF : k == 2'd2 ? 4'h7 : k == 2'd1 ? 4'h3 : 4'h1;
  endfunction
`ifdef LOADER_VERIFY_EN
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction
  logic [31:0] csum_w, csum_r, csum_r_nx;
  logic [ADDR_W-1:0] base_q, last_addr;
  logic [3:0] last_be;
  // readback of the final partial word is masked exactly like its write was
  assign csum_r_nx = csum_r + (bus.readdata & lane_mask(bus.address == last_addr ? last_be : 4'hF));
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      rem <= '0;
      lane <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      bus.address <= '0;
      bus.chipselect <= 1'b0;
      bus.write <= 1'b0;
      bus.byteenable <= '0;
      bus.writedata <= '0;
      bus.clken <= 1'b0;
      bus.s_ready <= 1'b0;
`ifdef LOADER_VERIFY_EN
      csum_w <= '0;
      csum_r <= '0;
      base_q <= '0;
      last_addr <= '0;
      last_be <= '0;
`endif
    end else if (abort) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      bus.chipselect <= 1'b0;
      bus.write <= 1'b0;
      bus.clken <= 1'b0;
      bus.s_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          error <= range_bad;
          bus.address <= base_addr;
          rem <= byte_len;
          lane <= 2'd0;
`ifdef LOADER_VERIFY_EN
          csum_w <= '0;
          csum_r <= '0;
          base_q <= base_addr;
          last_addr <= base_addr + ADDR_W'(nwords) - 1'b1;
          last_be <= lane_be(byte_len[1:0] - 2'd1);
`endif
          if (range_bad || byte_len == '0) begin
            state <= FINISH;
            done <= 1'b1;
          end else begin
            state <= FILL;
            busy <= 1'b1;
            bus.clken <= 1'b1;
            bus.s_ready <= 1'b1;
          end
        end
        FILL: if (bus.s_valid) begin
          // first byte of a word clears the upper lanes so a partial word carries zeros
          bus.writedata <= lane == 2'd0 ? {24'd0, bus.s_data}
                                        : bus.writedata | (32'(bus.s_data) << {lane, 3'b000});
          rem <= rem - 1'b1;
          lane <= lane + 1'b1;
          if (lane == 2'd3 || rem == LEN_W'(1)) begin
            state <= WRITE;
            bus.s_ready <= 1'b0;
            bus.chipselect <= 1'b1;
            bus.write <= 1'b1;
            bus.byteenable <= lane_be(lane);
          end
        end
        WRITE: begin
          bus.chipselect <= 1'b0;
          bus.write <= 1'b0;
`ifdef LOADER_VERIFY_EN
          csum_w <= csum_w + (bus.writedata & lane_mask(bus.byteenable));
`endif
          if (rem != '0) begin
            state <= FILL;
            bus.s_ready <= 1'b1;
            bus.address <= bus.address + 1'b1;
          end else begin
`ifdef LOADER_VERIFY_EN
            state <= VRD;
            bus.chipselect <= 1'b1;
            bus.address <= base_q;
`else
            state <= FINISH;
            done <= 1'b1;
`endif
          end
        end
`ifdef LOADER_VERIFY_EN
        VRD: begin
          bus.chipselect <= 1'b0;
          state <= VCHK;
        end
        VCHK: begin
          csum_r <= csum_r_nx;
          if (bus.address == last_addr) begin
            error <= csum_r_nx != csum_w;
            state <= FINISH;
            done <= 1'b1;
          end else begin
            bus.address <= bus.address + 1'b1;
            bus.chipselect <= 1'b1;
            state <= VRD;
          end
        end
`endif
        FINISH: begin
          done <= 1'b0;
          busy <= 1'b0;
          bus.clken <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lms_ctr_ram_loader.sv
// tb_lms_ctr_ram_loader: scoreboard bench for lms_ctr_ram_loader with a RAM model and byte source
module tb_lms_ctr_ram_loader;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [13:0] base_addr = '0;
  logic [15:0] byte_len = '0;
  logic busy, done, error;
  lms_ctr_ram_loader_if #(.ADDR_W(14)) bus();
  lms_ctr_ram_loader #(.ADDR_W(14), .DEPTH_WORDS(12288), .LEN_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .base_addr(base_addr), .byte_len(byte_len), .bus(bus),
    .busy(busy), .done(done), .error(error));
  always #5 clk = ~clk;

  int total = 0, bad = 0, n_writes = 0, n_done = 0;
  logic [63:0] exp_q[$];
  logic [7:0] src [0:15];
  bit stop_src = 1'b0;
  int corrupt_addr = -1;

  logic [31:0] mem [0:16383];
  logic [31:0] nw;
  initial for (int i = 0; i < 16384; i++) mem[i] = '0;
  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.readdata = '0;
  end
  always @(posedge clk) if (bus.chipselect && bus.clken) begin
    if (bus.write) begin
      nw = mem[bus.address];
      for (int b = 0; b < 4; b++) if (bus.byteenable[b]) nw[8*b +: 8] = bus.writedata[8*b +: 8];
      if (int'(bus.address) == corrupt_addr) nw[0] = ~nw[0];
      mem[bus.address] <= nw;
    end else bus.readdata <= mem[bus.address];
  end

  function automatic logic [63:0] mk(input int k, input int a, input logic [3:0] be, input logic [31:0] d);
    return {8'(k), 20'(a), be, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, req);
    end
  endtask

  logic [63:0] act;
  always @(negedge clk) if (reset_n) begin
    if (bus.chipselect) begin
      act = bus.write ? mk(0, int'(bus.address), bus.byteenable, bus.writedata) : mk(1, int'(bus.address), 4'h0, 32'h0);
      if (bus.write) n_writes++;
      if (exp_q.size() == 0) chk("unexpected_access", act, 64'h0);
      else chk(bus.write ? "write" : "read", act, exp_q.pop_front());
    end
    if (done) begin
      act = mk(2, 0, 4'h0, {31'd0, error});
      n_done++;
      if (exp_q.size() == 0) chk("unexpected_done", act, 64'h0);
      else chk("done", act, exp_q.pop_front());
    end
  end

  task automatic push_reads(input int base, input int n);
`ifdef LOADER_VERIFY_EN
    for (int i = 0; i < n; i++) exp_q.push_back(mk(1, base + i, 4'h0, 32'h0));
`endif
  endtask

  task automatic do_start(input int base, input int len);
    @(negedge clk);
    base_addr = 14'(base);
    byte_len = 16'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int n, input bit toggle);
    int idx = 0, cyc = 0;
    while (idx < n && cyc < 400 && !stop_src) begin
      bus.s_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      bus.s_data = src[idx];
      #1;
      if (bus.s_valid && bus.s_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    bus.s_valid = 1'b0;
    if (!stop_src) chk("stream_complete", 64'(idx), 64'(n));
  endtask

  task automatic wait_done(input int d0, input int max);
    int c = 0;
    while (n_done == d0 && c < max) begin
      @(negedge clk);
      c++;
    end
    chk("done_seen", 64'(n_done != d0), 64'd1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk("idle_after_done", {62'd0, busy, bus.clken}, 64'd0);
  endtask

  initial begin
    int d0, w0, c;
    #3;
    chk("reset_outputs", {busy, done, error, bus.s_ready, bus.chipselect, bus.write, bus.clken,
                          bus.byteenable, bus.writedata, bus.address}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) src[i] = 8'(i + 1);
    exp_q.push_back(mk(0, 0, 4'hF, 32'h04030201));
    exp_q.push_back(mk(0, 1, 4'hF, 32'h08070605));
    push_reads(0, 2);
    exp_q.push_back(mk(2, 0, 4'h0, 32'h0));
    d0 = n_done;
    do_start(0, 8);
    chk("busy_in_fill", {61'd0, busy, bus.clken, bus.s_ready}, 64'd7);
    send(8, 1'b0);
    wait_done(d0, 100);

    exp_q.push_back(mk(0, 16'h10, 4'hF, 32'h04030201));
    exp_q.push_back(mk(0, 16'h11, 4'h3, 32'h00000605));
    push_reads(16'h10, 2);
    exp_q.push_back(mk(2, 0, 4'h0, 32'h0));
    d0 = n_done;
    do_start(16'h10, 6);
    send(6, 1'b0);
    wait_done(d0, 100);

    exp_q.push_back(mk(2, 0, 4'h0, 32'h1));
    d0 = n_done;
    do_start(12287, 5);
    wait_done(d0, 10);
    repeat (3) @(negedge clk);
    chk("error_sticky", 64'(error), 64'd1);

    exp_q.push_back(mk(0, 12286, 4'hF, 32'h04030201));
    exp_q.push_back(mk(0, 12287, 4'hF, 32'h08070605));
    push_reads(12286, 2);
    exp_q.push_back(mk(2, 0, 4'h0, 32'h0));
    d0 = n_done;
    do_start(12286, 8);
    chk("error_cleared", 64'(error), 64'd0);
    send(8, 1'b0);
    wait_done(d0, 100);

    exp_q.push_back(mk(2, 0, 4'h0, 32'h0));
    d0 = n_done;
    do_start(16'h50, 0);
    wait_done(d0, 10);

    for (int i = 0; i < 12; i++) src[i] = 8'(8'h11 + i);
    exp_q.push_back(mk(0, 16'h40, 4'hF, 32'h14131211));
    exp_q.push_back(mk(0, 16'h41, 4'hF, 32'h18171615));
    d0 = n_done;
    w0 = n_writes;
    do_start(16'h40, 12);
    fork
      send(12, 1'b1);
      begin
        c = 0;
        while (n_writes < w0 + 2 && c < 200) begin
          @(negedge clk);
          c++;
        end
        chk("abort_two_writes", 64'(n_writes - w0), 64'd2);
        abort = 1'b1;
        stop_src = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", {61'd0, busy, bus.s_ready, bus.clken}, 64'd0);
      end
    join
    stop_src = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", 64'(n_done), 64'(d0));
    chk("abort_error_kept", 64'(error), 64'd0);

`ifdef LOADER_VERIFY_EN
    for (int i = 0; i < 16; i++) src[i] = 8'(8'h21 + i);
    for (int pass = 0; pass < 2; pass++) begin
      corrupt_addr = pass == 0 ? 16'h102 : -1;
      exp_q.push_back(mk(0, 16'h100, 4'hF, 32'h24232221));
      exp_q.push_back(mk(0, 16'h101, 4'hF, 32'h28272625));
      exp_q.push_back(mk(0, 16'h102, 4'hF, 32'h2C2B2A29));
      exp_q.push_back(mk(0, 16'h103, 4'hF, 32'h302F2E2D));
      push_reads(16'h100, 4);
      exp_q.push_back(mk(2, 0, 4'h0, pass == 0 ? 32'h1 : 32'h0));
      d0 = n_done;
      do_start(16'h100, 16);
      send(16, 1'b0);
      wait_done(d0, 100);
    end
    corrupt_addr = -1;
`endif

    for (int i = 0; i < 4; i++) src[i] = 8'(8'hC1 + i);
    do_start(16'h20, 8);
    send(2, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", {busy, done, error, bus.s_ready, bus.chipselect, bus.write, bus.clken,
                                bus.byteenable, bus.writedata, bus.address}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) src[i] = 8'(8'hA1 + i);
    exp_q.push_back(mk(0, 16'h30, 4'hF, 32'hA4A3A2A1));
    push_reads(16'h30, 1);
    exp_q.push_back(mk(2, 0, 4'h0, 32'h0));
    d0 = n_done;
    do_start(16'h30, 4);
    send(4, 1'b0);
    wait_done(d0, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
